// File: rtl/cali_dac_sweep.sv
// cali_dac_sweep: automated calibration-DAC amplitude scan.
// Walks the calibration DAC code from a start value to an inclusive stop value.
// For each code it strobes the DAC setter once, waits for the DAC output to settle,
// then fires a programmable number of calibration trigger pulses.
// Reset is synchronous and active-high. Every output except the constant DAC
// select is a register. Abort and reset override every state transition.
module cali_dac_sweep #(
  parameter int unsigned SETTLE_CYCLES = 2000,
  parameter int unsigned TRIG_WIDTH    = 4,
  parameter int unsigned TRIG_GAP      = 400
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        In_Sweep_Start,
  input  logic        In_Sweep_Abort,
  input  logic [11:0] In_Code_Start,
  input  logic [11:0] In_Code_Stop,
  input  logic [11:0] In_Code_Step,
  input  logic [7:0]  In_Pulses_Per_Step,
  output logic        Out_Start_Set_DAC,
  output logic [1:0]  Out_Sel_Cali_TA,
  output logic [11:0] Out_Set_Cali_DAC,
  output logic        Out_Cali_Trig,
  output logic        Out_Busy,
  output logic        Out_Step_Done,
  output logic        Out_Sweep_Done
);

  localparam int unsigned CODE_W  = 12;
  localparam int unsigned PULSE_W = 8;
  localparam int unsigned MAX_A   = (SETTLE_CYCLES > TRIG_WIDTH) ? SETTLE_CYCLES : TRIG_WIDTH;
  localparam int unsigned MAX_CYC = (MAX_A > TRIG_GAP) ? MAX_A : TRIG_GAP;
  localparam int unsigned TMR_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_TRIG   = 3'd3,
    S_GAP    = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [PULSE_W-1:0]  pcnt_q, pcnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   stop_q, stop_d;
  logic [CODE_W-1:0]   step_q, step_d;
  logic [PULSE_W-1:0]  pulses_q, pulses_d;
  logic                strobe_q, strobe_d;
  logic                trig_q, trig_d;
  logic                busy_q, busy_d;
  logic                step_done_q, step_done_d;
  logic                sweep_done_q, sweep_done_d;

  logic [CODE_W:0]     sum_c;
  logic [PULSE_W:0]    pcnt_inc_c;
  logic                settle_end_c;
  logic                trig_end_c;
  logic                gap_end_c;

  // Next code candidate with carry bit, so a carry always ends the sweep.
  assign sum_c      = {1'b0, code_q} + {1'b0, step_q};
  // Completed pulse count including the one whose gap is ending now.
  assign pcnt_inc_c = {1'b0, pcnt_q} + (PULSE_W + 1)'(1);

  // Terminal-count decodes for the shared phase timer.
  assign settle_end_c = (tmr_q == TMR_W'(SETTLE_CYCLES - 1));
  assign trig_end_c   = (tmr_q == TMR_W'(TRIG_WIDTH - 1));
  assign gap_end_c    = (tmr_q == TMR_W'(TRIG_GAP - 1));

  // Next-state and registered-output decode; abort overrides at the end.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    pcnt_d       = pcnt_q;
    code_d       = code_q;
    stop_d       = stop_q;
    step_d       = step_q;
    pulses_d     = pulses_q;
    busy_d       = busy_q;
    strobe_d     = 1'b0;
    trig_d       = 1'b0;
    step_done_d  = 1'b0;
    sweep_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (In_Sweep_Start) begin
          code_d   = In_Code_Start;
          stop_d   = In_Code_Stop;
          step_d   = (In_Code_Step == '0) ? CODE_W'(1) : In_Code_Step;
          pulses_d = (In_Pulses_Per_Step == '0) ? PULSE_W'(1) : In_Pulses_Per_Step;
          busy_d   = 1'b1;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        strobe_d = 1'b1;
        tmr_d    = '0;
        state_d  = S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_end_c) begin
          tmr_d   = '0;
          pcnt_d  = '0;
          state_d = S_TRIG;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_TRIG: begin
        trig_d = 1'b1;
        if (trig_end_c) begin
          tmr_d   = '0;
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_GAP: begin
        if (gap_end_c) begin
          tmr_d  = '0;
          pcnt_d = pcnt_inc_c[PULSE_W-1:0];
          if (pcnt_inc_c < {1'b0, pulses_q}) begin
            state_d = S_TRIG;
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_NEXT: begin
        step_done_d = 1'b1;
        if (sum_c > {1'b0, stop_q}) begin
          state_d = S_DONE;
        end else begin
          code_d  = sum_c[CODE_W-1:0];
          state_d = S_LOAD;
        end
      end

      S_DONE: begin
        sweep_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (In_Sweep_Abort) begin
      state_d      = S_IDLE;
      tmr_d        = '0;
      pcnt_d       = '0;
      code_d       = code_q;
      stop_d       = stop_q;
      step_d       = step_q;
      pulses_d     = pulses_q;
      busy_d       = 1'b0;
      strobe_d     = 1'b0;
      trig_d       = 1'b0;
      step_done_d  = 1'b0;
      sweep_done_d = 1'b0;
    end
  end

  // State, counters, latched configuration and outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      pcnt_q       <= '0;
      code_q       <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      pulses_q     <= '0;
      busy_q       <= 1'b0;
      strobe_q     <= 1'b0;
      trig_q       <= 1'b0;
      step_done_q  <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      pcnt_q       <= pcnt_d;
      code_q       <= code_d;
      stop_q       <= stop_d;
      step_q       <= step_d;
      pulses_q     <= pulses_d;
      busy_q       <= busy_d;
      strobe_q     <= strobe_d;
      trig_q       <= trig_d;
      step_done_q  <= step_done_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  // Output mapping; the select always addresses the calibration DAC.
  assign Out_Sel_Cali_TA   = 2'b00;
  assign Out_Start_Set_DAC = strobe_q;
  assign Out_Set_Cali_DAC  = code_q;
  assign Out_Cali_Trig     = trig_q;
  assign Out_Busy          = busy_q;
  assign Out_Step_Done     = step_done_q;
  assign Out_Sweep_Done    = sweep_done_q;

endmodule

// File: tb/tb_cali_dac_sweep.sv
// Bench for cali_dac_sweep: per-cycle comparison against a timeline model of the
// sweep, plus literal expectations for the directed scenarios.
module tb_cali_dac_sweep;

  localparam int SC = 8;
  localparam int WC = 2;
  localparam int GC = 4;

  logic        Clk;
  logic        Rst;
  logic        In_Sweep_Start;
  logic        In_Sweep_Abort;
  logic [11:0] In_Code_Start;
  logic [11:0] In_Code_Stop;
  logic [11:0] In_Code_Step;
  logic [7:0]  In_Pulses_Per_Step;
  logic        Out_Start_Set_DAC;
  logic [1:0]  Out_Sel_Cali_TA;
  logic [11:0] Out_Set_Cali_DAC;
  logic        Out_Cali_Trig;
  logic        Out_Busy;
  logic        Out_Step_Done;
  logic        Out_Sweep_Done;

  cali_dac_sweep #(
    .SETTLE_CYCLES(SC),
    .TRIG_WIDTH   (WC),
    .TRIG_GAP     (GC)
  ) dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .In_Sweep_Start    (In_Sweep_Start),
    .In_Sweep_Abort    (In_Sweep_Abort),
    .In_Code_Start     (In_Code_Start),
    .In_Code_Stop      (In_Code_Stop),
    .In_Code_Step      (In_Code_Step),
    .In_Pulses_Per_Step(In_Pulses_Per_Step),
    .Out_Start_Set_DAC (Out_Start_Set_DAC),
    .Out_Sel_Cali_TA   (Out_Sel_Cali_TA),
    .Out_Set_Cali_DAC  (Out_Set_Cali_DAC),
    .Out_Cali_Trig     (Out_Cali_Trig),
    .Out_Busy          (Out_Busy),
    .Out_Step_Done     (Out_Step_Done),
    .Out_Sweep_Done    (Out_Sweep_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  // A sweep accepted at edge t=0 is a list of codes, each occupying
  // L = 2 + S + P*(W+G) cycles; outputs follow from t alone.
  int m_valid = 0;
  int m_active = 0;
  int m_t, m_n, m_L, m_pp, m_code;
  int codes[$];
  int e_strobe, e_trig, e_busy, e_sd, e_swd;
  int live, idx, u, v, c, st;

  always @(posedge Clk) begin
    live = 0;
    if (Rst) begin
      m_valid = 1; m_active = 0; m_code = 0;
    end else if (In_Sweep_Abort) begin
      m_active = 0;
    end else if (m_active != 0) begin
      m_t = m_t + 1;
      live = 1;
      if (m_t >= m_n * m_L + 1) m_active = 0;
    end else if (In_Sweep_Start) begin
      st   = (In_Code_Step == 0) ? 1 : int'(In_Code_Step);
      m_pp = (In_Pulses_Per_Step == 0) ? 1 : int'(In_Pulses_Per_Step);
      codes.delete();
      c = int'(In_Code_Start);
      while (1) begin
        codes.push_back(c);
        if (c + st > int'(In_Code_Stop)) break;
        c = c + st;
      end
      m_n = codes.size();
      m_L = 2 + SC + m_pp * (WC + GC);
      m_t = 0;
      m_active = 1;
      live = 1;
    end
    if (live != 0) begin
      idx = m_t / m_L;
      if (idx > m_n - 1) idx = m_n - 1;
      m_code   = codes[idx];
      u        = m_t % m_L;
      v        = u - 2 - SC;
      e_strobe = int'((m_t < m_n * m_L) && (u == 1));
      e_trig   = int'((m_t < m_n * m_L) && (v >= 0) && (v < m_pp * (WC + GC)) && ((v % (WC + GC)) < WC));
      e_sd     = int'((m_t > 0) && (u == 0) && (m_t <= m_n * m_L));
      e_swd    = int'(m_t == m_n * m_L + 1);
      e_busy   = int'(m_t <= m_n * m_L);
    end else begin
      e_strobe = 0; e_trig = 0; e_sd = 0; e_swd = 0; e_busy = 0;
    end
  end

  // ---------------- compare and event counting ----------------
  int cyc = 0;
  int cnt_strobe = 0, cnt_trig = 0, cnt_sd = 0, cnt_swd = 0;
  int last_strobe = -1, strobe_gap = 0;
  int trig_run = 0, trig_last_run = 0;
  logic prev_strobe = 1'b0, prev_trig = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (m_valid != 0) begin
      chk("strobe",     int'(Out_Start_Set_DAC), e_strobe);
      chk("trig",       int'(Out_Cali_Trig),     e_trig);
      chk("busy",       int'(Out_Busy),          e_busy);
      chk("step_done",  int'(Out_Step_Done),     e_sd);
      chk("sweep_done", int'(Out_Sweep_Done),    e_swd);
      chk("code",       int'(Out_Set_Cali_DAC),  m_code);
      chk("sel",        int'(Out_Sel_Cali_TA),   0);
      if (Out_Start_Set_DAC && !prev_strobe) begin
        cnt_strobe++;
        if (last_strobe >= 0) strobe_gap = cyc - last_strobe;
        last_strobe = cyc;
      end
      if (Out_Cali_Trig && !prev_trig) cnt_trig++;
      if (Out_Cali_Trig) trig_run++;
      else begin
        if (trig_run > 0) trig_last_run = trig_run;
        trig_run = 0;
      end
      if (Out_Step_Done) cnt_sd++;
      if (Out_Sweep_Done) cnt_swd++;
      prev_strobe = Out_Start_Set_DAC;
      prev_trig   = Out_Cali_Trig;
    end
  end

  // ---------------- stimulus helpers ----------------
  int b_strobe, b_trig, b_sd, b_swd;

  task automatic snap();
    b_strobe = cnt_strobe; b_trig = cnt_trig; b_sd = cnt_sd; b_swd = cnt_swd;
  endtask

  task automatic counts(input string tag, input int ns, input int nt, input int nsd, input int nswd);
    chk({tag, "_strobes"},    cnt_strobe - b_strobe, ns);
    chk({tag, "_triggers"},   cnt_trig - b_trig,     nt);
    chk({tag, "_step_done"},  cnt_sd - b_sd,         nsd);
    chk({tag, "_sweep_done"}, cnt_swd - b_swd,       nswd);
  endtask

  task automatic do_start(input int s, input int stp, input int sp, input int p);
    @(negedge Clk);
    In_Code_Start      = 12'(s);
    In_Code_Step       = 12'(stp);
    In_Code_Stop       = 12'(sp);
    In_Pulses_Per_Step = 8'(p);
    In_Sweep_Start     = 1'b1;
    @(negedge Clk);
    In_Sweep_Start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (m_active != 0 && k < 5000) begin
      @(negedge Clk);
      k++;
    end
    chk({tag, "_idle_timeout"}, m_active, 0);
    repeat (2) @(negedge Clk);
  endtask

  task automatic wait_t(input int target);
    int k;
    k = 0;
    while (m_t < target && m_active != 0 && k < 2000) begin
      @(negedge Clk);
      k++;
    end
    chk("reach_t", int'(m_t >= target), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    Rst = 1'b1; In_Sweep_Start = 1'b0; In_Sweep_Abort = 1'b0;
    In_Code_Start = '0; In_Code_Stop = '0; In_Code_Step = '0; In_Pulses_Per_Step = '0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    chk("reset_busy", int'(Out_Busy), 0);
    chk("reset_code", int'(Out_Set_Cali_DAC), 0);
    chk("reset_trig", int'(Out_Cali_Trig), 0);
    repeat (2) @(negedge Clk);

    // Basic sweep: 100/150/200, two pulses per code.
    snap();
    do_start(100, 50, 200, 2);
    chk("basic_model_n", m_n, 3);
    chk("basic_model_L", m_L, 22);
    chk("basic_model_c2", codes[2], 200);
    chk("basic_code0", int'(Out_Set_Cali_DAC), 100);
    chk("basic_busy", int'(Out_Busy), 1);
    wait_idle("basic");
    counts("basic", 3, 6, 3, 1);
    chk("basic_strobe_gap", strobe_gap, 22);
    chk("basic_trig_width", trig_last_run, 2);
    chk("basic_last_code", int'(Out_Set_Cali_DAC), 200);

    // Zero step and zero pulses behave as one.
    snap();
    do_start(5, 0, 7, 0);
    wait_idle("zero");
    counts("zero", 3, 3, 3, 1);
    chk("zero_last_code", int'(Out_Set_Cali_DAC), 7);

    // Carry past the stop never wraps the code.
    snap();
    do_start(4000, 100, 4095, 1);
    wait_idle("nowrap");
    counts("nowrap", 1, 1, 1, 1);
    chk("nowrap_code", int'(Out_Set_Cali_DAC), 4000);

    // Start above stop sweeps just the start code.
    snap();
    do_start(300, 1, 100, 1);
    wait_idle("rev");
    counts("rev", 1, 1, 1, 1);
    chk("rev_code", int'(Out_Set_Cali_DAC), 300);

    // Abort during the first trigger of the second code, then restart.
    snap();
    do_start(100, 50, 200, 2);
    wait_t(22 + 2 + SC);
    chk("abort_pre_trig", int'(Out_Cali_Trig), 1);
    In_Sweep_Abort = 1'b1;
    @(negedge Clk);
    In_Sweep_Abort = 1'b0;
    chk("abort_trig", int'(Out_Cali_Trig), 0);
    chk("abort_busy", int'(Out_Busy), 0);
    chk("abort_code", int'(Out_Set_Cali_DAC), 150);
    repeat (2) @(negedge Clk);
    counts("abort", 2, 3, 1, 0);
    snap();
    do_start(600, 10, 620, 1);
    chk("restart_code", int'(Out_Set_Cali_DAC), 600);
    chk("restart_busy", int'(Out_Busy), 1);
    wait_idle("restart");
    counts("restart", 3, 3, 3, 1);

    // Start while busy is ignored; stop changes mid-sweep have no effect.
    snap();
    do_start(1000, 20, 1040, 1);
    repeat (5) @(negedge Clk);
    In_Code_Start  = 12'd2000;
    In_Code_Stop   = 12'd4095;
    In_Sweep_Start = 1'b1;
    @(negedge Clk);
    In_Sweep_Start = 1'b0;
    wait_idle("busy");
    counts("busy", 3, 3, 3, 1);
    chk("busy_last_code", int'(Out_Set_Cali_DAC), 1040);

    // Reset in the settle phase clears every output.
    do_start(700, 1, 710, 1);
    wait_t(4);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("rst_code", int'(Out_Set_Cali_DAC), 0);
    chk("rst_busy", int'(Out_Busy), 0);
    chk("rst_strobe", int'(Out_Start_Set_DAC), 0);
    repeat (3) @(negedge Clk);

    // Randomized sweeps with stray starts, input churn and occasional aborts.
    for (int it = 0; it < 20; it++) begin
      int s, stp, sp, p, ab, k;
      bit doab;
      s   = (it % 4 == 3) ? int'($urandom_range(4000, 4095)) : int'($urandom_range(0, 4000));
      stp = int'($urandom_range(0, 20));
      sp  = s + int'($urandom_range(0, 40)) - 5;
      if (sp > 4095) sp = 4095;
      if (sp < 0) sp = 0;
      p    = int'($urandom_range(0, 3));
      doab = ($urandom_range(0, 3) == 0);
      ab   = int'($urandom_range(1, 300));
      do_start(s, stp, sp, p);
      k = 0;
      while (m_active != 0 && k < 3000) begin
        @(negedge Clk);
        k++;
        In_Sweep_Abort = doab && (k == ab);
        In_Sweep_Start = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 15) == 0) In_Code_Stop = 12'($urandom);
        if ($urandom_range(0, 15) == 0) In_Code_Start = 12'($urandom);
      end
      In_Sweep_Abort = 1'b0;
      In_Sweep_Start = 1'b0;
      chk("rand_idle_timeout", m_active, 0);
      repeat (3) @(negedge Clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
